// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, FSM states,
// operation classes and instruction field positions.
package cu_pkg;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_MOV, CLS_LD, CLS_ST, CLS_CMP, CLS_BEQ, CLS_BT, CLS_J
    } op_class_t;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_MUL = 4'h8;
    localparam logic [3:0] OP_MOV = 4'h9;
    localparam logic [3:0] OP_LD  = 4'hA;
    localparam logic [3:0] OP_ST  = 4'hB;
    localparam logic [3:0] OP_CMP = 4'hC;
    localparam logic [3:0] OP_BEQ = 4'hD;
    localparam logic [3:0] OP_BT  = 4'hE;
    localparam logic [3:0] OP_J   = 4'hF;

    localparam int OPC_MSB    = 15;
    localparam int OPC_LSB    = 12;
    localparam int IMMSEL_BIT = 11;
    localparam int RD_LSB     = 8;
    localparam int RS_LSB     = 5;
    localparam int RT_LSB     = 0;
    localparam int IMM5_MSB   = 4;
    localparam int IMM8_MSB   = 7;

    function automatic op_class_t op_class(input logic [3:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_NOT, OP_SHL, OP_SHR, OP_MUL: cls = CLS_ALU;
            OP_MOV: cls = CLS_MOV;
            OP_LD:  cls = CLS_LD;
            OP_ST:  cls = CLS_ST;
            OP_CMP: cls = CLS_CMP;
            OP_BEQ: cls = CLS_BEQ;
            OP_BT:  cls = CLS_BT;
            default: cls = CLS_J;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction decoder: splits a 16-bit word into register
// addresses, sign-extended immediate / branch offset and operation class.
module cu_decoder
    import cu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PC_W   = 8,
    parameter int REG_AW = 3
) (
    input  logic [15:0]              i_instr,
    output logic [3:0]               o_opcode,
    output op_class_t                o_cls,
    output logic [REG_AW-1:0]        o_rd,
    output logic [REG_AW-1:0]        o_rs,
    output logic [REG_AW-1:0]        o_rt,
    output logic signed [DATA_W-1:0] o_imm,
    output logic signed [PC_W-1:0]   o_off,
    output logic                     o_imm_sel,
    output logic                     o_bt_gt
);

    always_comb begin
        o_opcode  = i_instr[OPC_MSB:OPC_LSB];
        o_cls     = op_class(o_opcode);
        o_rd      = i_instr[RD_LSB +: REG_AW];
        o_rt      = i_instr[RT_LSB +: REG_AW];
        o_off     = PC_W'($signed(i_instr[IMM8_MSB:0]));
        o_bt_gt   = i_instr[IMMSEL_BIT];
        o_rs      = o_rd;
        o_imm     = DATA_W'($signed(i_instr[IMM8_MSB:0]));
        o_imm_sel = 1'b0;
        if (o_cls == CLS_ALU) begin
            o_rs  = i_instr[RS_LSB +: REG_AW];
            o_imm = DATA_W'($signed(i_instr[IMM5_MSB:0]));
        end else if (o_cls inside {CLS_MOV, CLS_LD, CLS_ST, CLS_CMP}) begin
            // Register-form ALU ops always take operand B from rt; only the
            // immediate-capable ops honour the format bit.
            o_imm_sel = ~i_instr[IMMSEL_BIT];
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Fetch/decode/execute/memory/writeback sequencer with req/ready memory handshakes.
// Optional retired-instruction counter enabled by defining CU_PERF_CNT_EN.
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int              DATA_W   = 16,
    parameter int              PC_W     = 8,
    parameter int              REG_AW   = 3,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ready,
    input  logic              zero_flag,
    input  logic              pos_flag,
    output logic              rf_write,
    output logic [REG_AW-1:0] rs_addr,
    output logic [REG_AW-1:0] rt_addr,
    output logic [REG_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] imm_data,
    output logic [3:0]        alu_sel,
    output logic              imm_sel,
    output logic              mem_sel,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    output logic [31:0]       retired_cnt
);

    state_t                    r_state;
    logic [PC_W-1:0]           r_pc;
    logic                      r_imem_req, r_dmem_req, r_dmem_we;
    logic                      r_rf_write, r_mem_sel, r_imm_sel, r_halted;
    logic [REG_AW-1:0]         r_rd, r_rs, r_rt;
    logic signed [DATA_W-1:0]  r_imm;
    logic [3:0]                r_alu_sel;

    logic [15:0]               r_instr;
    logic [3:0]                r_opcode;
    op_class_t                 r_cls;
    logic signed [PC_W-1:0]    r_off;
    logic                      r_bt_gt;

    logic [3:0]                w_opcode;
    op_class_t                 w_cls;
    logic [REG_AW-1:0]         w_rd, w_rs, w_rt;
    logic signed [DATA_W-1:0]  w_imm;
    logic signed [PC_W-1:0]    w_off;
    logic                      w_imm_sel, w_bt_gt;
    logic                      w_taken;
    logic [PC_W-1:0]           w_exec_pc;
    logic                      w_fetch_hit;

    cu_decoder #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW)) u_dec (
        .i_instr   (r_instr),
        .o_opcode  (w_opcode),
        .o_cls     (w_cls),
        .o_rd      (w_rd),
        .o_rs      (w_rs),
        .o_rt      (w_rt),
        .o_imm     (w_imm),
        .o_off     (w_off),
        .o_imm_sel (w_imm_sel),
        .o_bt_gt   (w_bt_gt)
    );

    // A fetch only lands while our own request is up; stale valids are dropped.
    assign w_fetch_hit = (r_state == S_FETCH) && r_imem_req && imem_valid;

    always_comb begin
        w_taken = 1'b0;
        case (r_cls)
            CLS_BEQ: w_taken = zero_flag;
            CLS_BT:  w_taken = r_bt_gt ? pos_flag : (!pos_flag && !zero_flag);
            default: w_taken = 1'b0;
        endcase
        w_exec_pc = r_pc;
        if (r_cls == CLS_J)
            w_exec_pc = r_instr[PC_W-1:0];
        else if (w_taken)
            w_exec_pc = r_pc + r_off;
    end

    // Instruction word and decoded control fields carry no reset.
    always_ff @(posedge clock) begin
        if (w_fetch_hit)
            r_instr <= imem_rdata;
        if (r_state == S_DECODE) begin
            r_opcode <= w_opcode;
            r_cls    <= w_cls;
            r_off    <= w_off;
            r_bt_gt  <= w_bt_gt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_rf_write <= 1'b0;
            r_mem_sel  <= 1'b0;
            r_imm_sel  <= 1'b0;
            r_halted   <= 1'b0;
            r_rd       <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_imm      <= '0;
            r_alu_sel  <= 4'hF;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (&r_pc) begin
                        r_imem_req <= 1'b0;
                        r_halted   <= 1'b1;
                        r_state    <= S_HALT;
                    end else if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
                    end else if (imem_valid) begin
                        r_imem_req <= 1'b0;
                        r_pc       <= r_pc + PC_W'(1);
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_rd      <= w_rd;
                    r_rs      <= w_rs;
                    r_rt      <= w_rt;
                    r_imm     <= w_imm;
                    r_imm_sel <= w_imm_sel;
                    r_state   <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    r_alu_sel <= r_opcode;
                    case (r_cls)
                        CLS_ALU, CLS_MOV: begin
                            r_rf_write <= 1'b1;
                            r_state    <= S_WRITEBACK;
                        end
                        CLS_LD: begin
                            r_mem_sel  <= 1'b1;
                            r_dmem_req <= 1'b1;
                            r_dmem_we  <= 1'b0;
                            r_state    <= S_MEMORY;
                        end
                        CLS_ST: begin
                            r_dmem_req <= 1'b1;
                            r_dmem_we  <= 1'b1;
                            r_state    <= S_MEMORY;
                        end
                        default: begin
                            // Request is withheld when the next fetch would halt.
                            r_pc       <= w_exec_pc;
                            r_imem_req <= ~&w_exec_pc;
                            r_state    <= S_FETCH;
                        end
                    endcase
                end
                S_MEMORY: begin
                    if (dmem_ready) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        if (r_cls == CLS_LD) begin
                            r_rf_write <= 1'b1;
                            r_state    <= S_WRITEBACK;
                        end else begin
                            r_imem_req <= ~&r_pc;
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_WRITEBACK: begin
                    r_rf_write <= 1'b0;
                    r_mem_sel  <= 1'b0;
                    r_imem_req <= ~&r_pc;
                    r_state    <= S_FETCH;
                end
                S_HALT: begin
                    r_imem_req <= 1'b0;
                    r_dmem_req <= 1'b0;
                    r_rf_write <= 1'b0;
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

`ifdef CU_PERF_CNT_EN
    logic        w_retire;
    logic [31:0] r_retired;

    assign w_retire = (r_state == S_WRITEBACK) ||
                      (r_state == S_MEMORY && dmem_ready && r_cls == CLS_ST) ||
                      (r_state == S_EXECUTE &&
                       r_cls inside {CLS_CMP, CLS_BEQ, CLS_BT, CLS_J});

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_retired <= 32'd0;
        else if (w_retire)
            r_retired <= r_retired + 32'd1;
    end

    assign retired_cnt = r_retired;
`else
    assign retired_cnt = 32'd0;
`endif

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign dmem_req  = r_dmem_req;
    assign dmem_we   = r_dmem_we;
    assign rf_write  = r_rf_write;
    assign rd_addr   = r_rd;
    assign rs_addr   = r_rs;
    assign rt_addr   = r_rt;
    assign imm_data  = r_imm;
    assign imm_sel   = r_imm_sel;
    assign mem_sel   = r_mem_sel;
    assign alu_sel   = r_alu_sel;
    assign halted    = r_halted;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (PC_W=5) with a zero/variable-wait
// memory model; retired_cnt expectations follow CU_PERF_CNT_EN.
module tb_multicycle_control_unit;

    localparam int DATA_W = 16;
    localparam int PC_W   = 5;
    localparam int REG_AW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              imem_req, imem_valid;
    logic [PC_W-1:0]   imem_addr, pc;
    logic [15:0]       imem_rdata;
    logic              dmem_req, dmem_we, dmem_ready;
    logic              zero_flag, pos_flag;
    logic              rf_write, imm_sel, mem_sel, halted;
    logic [REG_AW-1:0] rs_addr, rt_addr, rd_addr;
    logic [DATA_W-1:0] imm_data;
    logic [3:0]        alu_sel;
    logic [31:0]       retired_cnt;

    logic [15:0]       rom [32];
    logic              ivalid_auto, ivalid_force;
    int                dly;
    int                dcnt;
    int                n_checks = 0;
    int                n_fail   = 0;

`ifdef CU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW), .RESET_PC(5'd0)
    ) dut (
        .clock(clk), .reset(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .zero_flag(zero_flag), .pos_flag(pos_flag),
        .rf_write(rf_write), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .imm_data(imm_data), .alu_sel(alu_sel), .imm_sel(imm_sel), .mem_sel(mem_sel),
        .pc(pc), .halted(halted), .retired_cnt(retired_cnt)
    );

    assign imem_rdata = rom[imem_addr];
    assign imem_valid = ivalid_auto ? imem_req : ivalid_force;
    assign dmem_ready = dmem_req && (dcnt == dly);

    always @(posedge clk) begin
        if (dmem_req) dcnt <= dcnt + 1;
        else          dcnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("excl", {31'd0, (imem_req & dmem_req) | (rf_write & dmem_req)}, 32'd0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [31:0] perf(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
        rom[0] = 16'h0143;  // ADD r1,r2,r3
        rom[1] = 16'hA204;  // LD  r2,#4
        rom[2] = 16'hB305;  // ST  r3,#5
        rom[3] = 16'hC100;  // CMP r1
        rom[4] = 16'h9107;  // MOV r1,#7
        rom[5] = 16'hD0FE;  // BEQ -2
        rom[6] = 16'hE801;  // BGT +1
        rom[8] = 16'hF01F;  // J 0x1F
        rst = 1'b1; ivalid_auto = 1'b1; ivalid_force = 1'b0;
        zero_flag = 1'b0; pos_flag = 1'b0; dly = 0;
        dcnt = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_req", {31'd0, imem_req}, 0);
        check("rst_pc", {27'd0, pc}, 0);
        check("rst_alu_sel", {28'd0, alu_sel}, 32'hF);
        check("rst_halted", {31'd0, halted}, 0);
        check("rst_rf_write", {31'd0, rf_write}, 0);
        check("rst_dmem_req", {31'd0, dmem_req}, 0);
        check("rst_retired", retired_cnt, 0);
        @(negedge clk) rst = 1'b0;

        // ADD: F D E W
        tick();
        check("add_f_req", {31'd0, imem_req}, 1);
        check("add_f_addr", {27'd0, imem_addr}, 0);
        tick();
        check("add_d_pc", {27'd0, pc}, 1);
        check("add_d_req", {31'd0, imem_req}, 0);
        tick();
        check("add_e_rd", {29'd0, rd_addr}, 1);
        check("add_e_rs", {29'd0, rs_addr}, 2);
        check("add_e_rt", {29'd0, rt_addr}, 3);
        check("add_e_imm_sel", {31'd0, imm_sel}, 0);
        check("add_e_rf_write", {31'd0, rf_write}, 0);
        tick();
        check("add_w_rf_write", {31'd0, rf_write}, 1);
        check("add_w_alu_sel", {28'd0, alu_sel}, 0);
        tick();
        check("add_next_rf_write", {31'd0, rf_write}, 0);
        check("add_next_addr", {27'd0, imem_addr}, 1);

        // LD with 3-cycle data wait
        dly = 3;
        ticks(3);
        check("ld_m_req", {31'd0, dmem_req}, 1);
        check("ld_m_we", {31'd0, dmem_we}, 0);
        check("ld_m_mem_sel", {31'd0, mem_sel}, 1);
        n = 0;
        while (dmem_req && n < 10) begin n++; tick(); end
        check("ld_req_len", n, 4);
        check("ld_w_rf_write", {31'd0, rf_write}, 1);
        check("ld_w_mem_sel", {31'd0, mem_sel}, 1);
        check("ld_w_rd", {29'd0, rd_addr}, 2);
        tick();
        check("ld_next_mem_sel", {31'd0, mem_sel}, 0);
        check("ld_next_addr", {27'd0, imem_addr}, 2);

        // ST zero-wait: F D E M
        dly = 0;
        ticks(3);
        check("st_m_req", {31'd0, dmem_req}, 1);
        check("st_m_we", {31'd0, dmem_we}, 1);
        tick();
        check("st_next_req", {31'd0, imem_req}, 1);
        check("st_next_addr", {27'd0, imem_addr}, 3);

        // CMP: F D E
        ticks(3);
        check("cmp_next_addr", {27'd0, imem_addr}, 4);

        // MOV then BEQ -2 taken
        zero_flag = 1'b1;
        ticks(4);
        check("mov_next_addr", {27'd0, imem_addr}, 5);
        ticks(3);
        check("beq_taken_pc", {27'd0, pc}, 4);
        check("beq_taken_req", {31'd0, imem_req}, 1);
        check("retired_6", retired_cnt, perf(6));

        // MOV then BEQ not taken
        zero_flag = 1'b0;
        ticks(4);
        ticks(3);
        check("beq_nt_pc", {27'd0, pc}, 6);

        // BGT +1 taken
        pos_flag = 1'b1;
        ticks(3);
        check("bgt_pc", {27'd0, pc}, 8);

        // J 0x1F -> halt
        ticks(3);
        check("j_pc", {27'd0, pc}, 32'h1F);
        check("j_req", {31'd0, imem_req}, 0);
        tick();
        check("halt_flag", {31'd0, halted}, 1);
        check("halt_req", {31'd0, imem_req}, 0);
        ticks(3);
        check("halt_hold_req", {31'd0, imem_req}, 0);
        check("halt_hold_flag", {31'd0, halted}, 1);
        check("retired_10", retired_cnt, perf(10));

        // Reset out of halt, then reset while a fetch is waiting
        rst = 1'b1;
        #1;
        check("rst2_halted", {31'd0, halted}, 0);
        check("rst2_pc", {27'd0, pc}, 0);
        check("rst2_retired", retired_cnt, 0);
        ivalid_auto = 1'b0;
        @(negedge clk) rst = 1'b0;
        ticks(2);
        check("wait_req", {31'd0, imem_req}, 1);
        check("wait_pc", {27'd0, pc}, 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_req", {31'd0, imem_req}, 0);
        check("midrst_pc", {27'd0, pc}, 0);
        ivalid_force = 1'b1;
        @(negedge clk) rst = 1'b0;
        tick();
        check("late_valid_pc", {27'd0, pc}, 0);
        check("late_valid_req", {31'd0, imem_req}, 1);
        tick();
        check("refetch_pc", {27'd0, pc}, 1);
        check("refetch_req", {31'd0, imem_req}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
